load_store_unit: RTL and testbench

Memory-stage load/store unit for the 5-stage RV32I pipeline. It takes the load/store request produced by `stage_execute` (effective address in `execute_alu_result`) and drives a single-outstanding-request data-memory bus. It formats load data (byte/half/word, signed/unsigned) into `mem_read_data` for `stage_writeback`. It holds the pipeline through `lsu_stall` while an access is in flight, and raises `lsu_fault` on misaligned, illegal or timed-out accesses.

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues one data-memory access at a time,
// formats load data for writeback and stalls the pipeline while busy.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        execute_mem_read,
    input  logic        execute_mem_write,
    input  logic [2:0]  execute_funct3,
    input  logic [31:0] execute_alu_result,
    input  logic [31:0] execute_store_data,
    output logic        lsu_stall,
    output logic        lsu_fault,
    output logic [31:0] mem_read_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_next;
    logic        fault_flag;
    logic [31:0] count;
    logic [1:0]  byte_off;
    logic [2:0]  funct3_q;
    logic        is_load;

    logic        request;
    logic        funct3_ok;
    logic        misaligned;
    logic        legal;
    logic        timed_out;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data across all lanes so any enabled lane carries it.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Extract the addressed byte/half and sign- or zero-extend it.
    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        case (off)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h  = off[1] ? rdata[31:16] : rdata[15:0];
        sb = b;
        sh = h;
        case (f3)
            3'b000:  return 32'(sb);
            3'b001:  return 32'(sh);
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    assign request   = execute_mem_read | execute_mem_write;
    assign timed_out = (TIMEOUT != 0) && (count == TIMEOUT);

    // Classify the incoming request: funct3 legality, alignment, read+write conflict.
    always_comb begin
        funct3_ok  = 1'b0;
        misaligned = 1'b0;
        if (execute_mem_read) begin
            case (execute_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
                default:                                funct3_ok = 1'b0;
            endcase
        end else begin
            case (execute_funct3)
                3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
                default:                funct3_ok = 1'b0;
            endcase
        end
        if (execute_funct3[1:0] == 2'b01 && execute_alu_result[0])
            misaligned = 1'b1;
        if (execute_funct3[1:0] == 2'b10 && execute_alu_result[1:0] != 2'b00)
            misaligned = 1'b1;
        legal = funct3_ok && !misaligned && !(execute_mem_read && execute_mem_write);
    end

    // Next-state and combinational stall/fault outputs.
    always_comb begin
        state_next = state;
        lsu_stall  = 1'b0;
        lsu_fault  = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    lsu_stall  = 1'b1;
                    state_next = legal ? REQ : DONE;
                end
            end
            REQ: begin
                lsu_stall = 1'b1;
                if (dmem_ack || timed_out)
                    state_next = DONE;
            end
            DONE: begin
                lsu_fault  = fault_flag;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Bus outputs, load result, fault flag and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_flag    <= 1'b0;
            count         <= 32'd0;
            byte_off      <= 2'b00;
            funct3_q      <= 3'b000;
            is_load       <= 1'b0;
            mem_read_data <= 32'd0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'd0;
            dmem_be       <= 4'd0;
            dmem_wdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        fault_flag <= !legal;
                        count      <= 32'd0;
                        byte_off   <= execute_alu_result[1:0];
                        funct3_q   <= execute_funct3;
                        is_load    <= execute_mem_read;
                        if (legal) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= execute_mem_write;
                            dmem_addr  <= {execute_alu_result[31:2], 2'b00};
                            dmem_be    <= execute_mem_write
                                          ? store_be(execute_funct3, execute_alu_result[1:0])
                                          : 4'b1111;
                            dmem_wdata <= execute_mem_write
                                          ? store_wdata(execute_funct3, execute_store_data)
                                          : 32'd0;
                        end else if (execute_mem_read) begin
                            mem_read_data <= 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (is_load)
                            mem_read_data <= load_format(funct3_q, byte_off, dmem_rdata);
                    end else if (timed_out) begin
                        dmem_req   <= 1'b0;
                        fault_flag <= 1'b1;
                        if (is_load)
                            mem_read_data <= 32'd0;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout, reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        execute_mem_read;
    logic        execute_mem_write;
    logic [2:0]  execute_funct3;
    logic [31:0] execute_alu_result;
    logic [31:0] execute_store_data;
    logic        lsu_stall;
    logic        lsu_fault;
    logic [31:0] mem_read_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT(15)) dut (
        .clk                (clk),
        .rst                (rst),
        .execute_mem_read   (execute_mem_read),
        .execute_mem_write  (execute_mem_write),
        .execute_funct3     (execute_funct3),
        .execute_alu_result (execute_alu_result),
        .execute_store_data (execute_store_data),
        .lsu_stall          (lsu_stall),
        .lsu_fault          (lsu_fault),
        .mem_read_data      (mem_read_data),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_be            (dmem_be),
        .dmem_wdata         (dmem_wdata),
        .dmem_rdata         (dmem_rdata),
        .dmem_ack           (dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Move to the middle of the next clock cycle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_idle();
        execute_mem_read   = 1'b0;
        execute_mem_write  = 1'b0;
        execute_funct3     = 3'b000;
        execute_alu_result = 32'd0;
        execute_store_data = 32'd0;
    endtask

    // Load with ack in cycle 1; result checked in DONE (cycle 2).
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp_addr, input logic [31:0] rd,
                           input logic [31:0] exp);
        execute_mem_read   = 1'b1;
        execute_funct3     = f3;
        execute_alu_result = a;
        #1 chk({tag, "_stall0"}, 32'(lsu_stall), 32'd1);
        tick();
        drive_idle();
        dmem_rdata = rd;
        dmem_ack   = 1'b1;
        chk({tag, "_req1"},  32'(dmem_req),  32'd1);
        chk({tag, "_addr"},  dmem_addr,      exp_addr);
        chk({tag, "_be"},    32'(dmem_be),   32'hF);
        chk({tag, "_we"},    32'(dmem_we),   32'd0);
        chk({tag, "_stall1"},32'(lsu_stall), 32'd1);
        tick();
        dmem_ack = 1'b0;
        chk({tag, "_stall2"}, 32'(lsu_stall), 32'd0);
        chk({tag, "_fault2"}, 32'(lsu_fault), 32'd0);
        chk({tag, "_req2"},   32'(dmem_req),  32'd0);
        chk({tag, "_data"},   mem_read_data,  exp);
        tick();
    endtask

    // Store with ack in cycle 1; load result must stay at prev.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] prev);
        execute_mem_write  = 1'b1;
        execute_funct3     = f3;
        execute_alu_result = a;
        execute_store_data = d;
        #1 chk({tag, "_stall0"}, 32'(lsu_stall), 32'd1);
        tick();
        drive_idle();
        dmem_ack = 1'b1;
        chk({tag, "_req1"},  32'(dmem_req), 32'd1);
        chk({tag, "_we"},    32'(dmem_we),  32'd1);
        chk({tag, "_addr"},  dmem_addr,     exp_addr);
        chk({tag, "_be"},    32'(dmem_be),  32'(exp_be));
        chk({tag, "_wdata"}, dmem_wdata,    exp_wdata);
        tick();
        dmem_ack = 1'b0;
        chk({tag, "_stall2"}, 32'(lsu_stall), 32'd0);
        chk({tag, "_data"},   mem_read_data,  prev);
        tick();
    endtask

    // Rejected request: no bus access, fault pulse in cycle 1, load data zeroed.
    task automatic do_fault(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a);
        execute_mem_read   = rd;
        execute_mem_write  = wr;
        execute_funct3     = f3;
        execute_alu_result = a;
        execute_store_data = 32'hA5A5A5A5;
        #1 chk({tag, "_stall0"}, 32'(lsu_stall), 32'd1);
        tick();
        drive_idle();
        chk({tag, "_req1"},   32'(dmem_req),  32'd0);
        chk({tag, "_fault1"}, 32'(lsu_fault), 32'd1);
        chk({tag, "_stall1"}, 32'(lsu_stall), 32'd0);
        chk({tag, "_data"},   mem_read_data,  32'd0);
        tick();
        chk({tag, "_fault2"}, 32'(lsu_fault), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        dmem_rdata = 32'd0;
        dmem_ack   = 1'b0;
        drive_idle();
        tick();
        tick();
        chk("rst_req",   32'(dmem_req),  32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_fault", 32'(lsu_fault), 32'd0);
        chk("rst_data",  mem_read_data,  32'd0);
        chk("rst_addr",  dmem_addr,      32'd0);
        chk("rst_be",    32'(dmem_be),   32'd0);
        rst = 1'b0;
        tick();

        // Loads of each width and sign.
        do_load("lw",  3'b010, 32'h100, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lb",  3'b000, 32'h103, 32'h100, 32'h80FF0000, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h100, 32'h80FF0000, 32'h00000080);
        do_load("lh",  3'b001, 32'h102, 32'h100, 32'h80FF0000, 32'hFFFF80FF);
        do_load("lhu", 3'b101, 32'h102, 32'h100, 32'h80FF0000, 32'h000080FF);

        // Stores leave the previous load result untouched.
        do_store("sb", 3'b000, 32'h201, 32'h12345678, 32'h200, 4'b0010, 32'h78787878, 32'h000080FF);
        do_store("sh", 3'b001, 32'h202, 32'h0000ABCD, 32'h200, 4'b1100, 32'hABCDABCD, 32'h000080FF);
        do_store("sw", 3'b010, 32'h300, 32'hCAFEF00D, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h000080FF);

        // Rejected requests; reload a nonzero value first so the clear is visible.
        do_fault("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102);
        do_load("rl1", 3'b010, 32'h100, 32'h100, 32'h11223344, 32'h11223344);
        do_fault("rw_both", 1'b1, 1'b1, 3'b010, 32'h100);
        do_load("rl2", 3'b010, 32'h100, 32'h100, 32'h11223344, 32'h11223344);
        do_fault("f3_011", 1'b1, 1'b0, 3'b011, 32'h100);

        // Timeout: no ack for a legal load.
        do_load("rl3", 3'b010, 32'h100, 32'h100, 32'h55667788, 32'h55667788);
        execute_mem_read   = 1'b1;
        execute_funct3     = 3'b010;
        execute_alu_result = 32'h104;
        for (int c = 1; c <= 16; c++) begin
            tick();
            drive_idle();
            chk($sformatf("to_req_c%0d", c), 32'(dmem_req), 32'd1);
        end
        chk("to_stall_c16", 32'(lsu_stall), 32'd1);
        tick();
        chk("to_req_c17",   32'(dmem_req),  32'd0);
        chk("to_fault_c17", 32'(lsu_fault), 32'd1);
        chk("to_stall_c17", 32'(lsu_stall), 32'd0);
        chk("to_data_c17",  mem_read_data,  32'd0);
        dmem_rdata = 32'h99999999;
        dmem_ack   = 1'b1;
        tick();
        chk("to_fault_c18", 32'(lsu_fault), 32'd0);
        chk("to_req_c18",   32'(dmem_req),  32'd0);
        chk("to_stall_c18", 32'(lsu_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("to_late_data", mem_read_data,  32'd0);

        // Reset in the second REQ cycle.
        do_load("rl4", 3'b010, 32'h100, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        execute_mem_read   = 1'b1;
        execute_funct3     = 3'b010;
        execute_alu_result = 32'h108;
        tick();
        drive_idle();
        chk("mr_req_c1", 32'(dmem_req), 32'd1);
        tick();
        chk("mr_req_c2", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_req",   32'(dmem_req),  32'd0);
        chk("mr_stall", 32'(lsu_stall), 32'd0);
        dmem_rdata = 32'h77777777;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("mr_late_req",   32'(dmem_req),  32'd0);
        chk("mr_late_data",  mem_read_data,  32'd0);
        chk("mr_late_fault", 32'(lsu_fault), 32'd0);
        do_load("after_rst", 3'b010, 32'h10C, 32'h10C, 32'h0BADF00D, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
